// File: rtl/alu_core.sv
// ============================================================================
//  Module      : alu_core
//  Description : Registered accumulator ALU. It combines A with B (R-type) or
//                with I (I-type) and registers the result and a branch flag.
//                The optional flag outputs are enabled by defining ALU_FLAGS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             En,
    input  logic [WIDTH-1:0] AccumulatorIn,
    input  logic [WIDTH-1:0] OperandIn,
    input  logic [WIDTH-1:0] ImmediateIn,
    input  logic             Type,
    input  logic [3:0]       RTypeOP,
    input  logic [2:0]       ITypeOP,
    output logic [WIDTH-1:0] Out,
    output logic             Branch
`ifdef ALU_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry
`endif
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_i;
    logic [WIDTH-1:0] w_result;
    logic             w_branch;
    logic [WIDTH:0]   w_sum_b;
    logic [WIDTH:0]   w_sum_i;

    assign w_a     = AccumulatorIn;
    assign w_b     = OperandIn;
    assign w_i     = ImmediateIn;
    assign w_sum_b = {1'b0, w_a} + {1'b0, w_b};
    assign w_sum_i = {1'b0, w_a} + {1'b0, w_i};

    always_comb begin
        w_result = w_a;
        w_branch = 1'b0;
        if (Type) begin
            case (RTypeOP)
                4'd0:    w_result = w_b;
                4'd1:    w_result = w_a & w_b;
                4'd2:    w_result = w_a | w_b;
                4'd3:    w_result = w_a ^ w_b;
                4'd4:    w_result = w_sum_b[WIDTH-1:0];
                4'd5:    w_result = w_a - w_b;
                4'd6:    w_result = w_a << w_b[2:0];
                4'd7:    w_result = w_a >> w_b[2:0];
                4'd8:    w_result = $signed(w_a) >>> w_b[2:0];
                4'd9:    w_result = ~w_a;
                4'd10:   w_result = ($signed(w_a) < $signed(w_b)) ? c_one : '0;
                4'd11:   w_result = (w_a < w_b) ? c_one : '0;
                4'd12:   w_branch = (w_a == w_b);
                4'd13:   w_branch = (w_a != w_b);
                4'd14:   w_branch = ($signed(w_a) < $signed(w_b));
                default: w_result = w_a;
            endcase
        end else begin
            case (ITypeOP)
                3'd0:    w_result = w_i;
                3'd1:    w_result = w_sum_i[WIDTH-1:0];
                3'd2:    w_result = w_a & w_i;
                3'd3:    w_result = w_a | w_i;
                3'd4:    w_result = w_a ^ w_i;
                3'd5:    w_result = w_a << w_i[2:0];
                3'd6:    w_result = w_a >> w_i[2:0];
                default: w_branch = (w_a == w_i);
            endcase
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            Out    <= '0;
            Branch <= 1'b0;
        end else if (En) begin
            Out    <= w_result;
            Branch <= w_branch;
        end
    end

`ifdef ALU_FLAGS_EN
    logic w_carry;

    // Carry is the adder carry-out for ADD/ADDI and the inverted borrow for SUB.
    always_comb begin
        w_carry = 1'b0;
        if (Type) begin
            if (RTypeOP == 4'd4)
                w_carry = w_sum_b[WIDTH];
            else if (RTypeOP == 4'd5)
                w_carry = (w_a >= w_b);
        end else if (ITypeOP == 3'd1) begin
            w_carry = w_sum_i[WIDTH];
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Carry    <= 1'b0;
        end else if (En) begin
            Zero     <= (w_result == '0);
            Negative <= w_result[WIDTH-1];
            Carry    <= w_carry;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
// Scoreboard testbench for alu_core: a driver pushes model expectations and a
// monitor pops and compares them one cycle later.
`default_nettype none

module tb_alu_core;

    logic       Clk = 1'b0;
    logic       ResetN = 1'b0;
    logic       En = 1'b0;
    logic [7:0] AccumulatorIn = '0;
    logic [7:0] OperandIn = '0;
    logic [7:0] ImmediateIn = '0;
    logic       Type = 1'b0;
    logic [3:0] RTypeOP = '0;
    logic [2:0] ITypeOP = '0;
    logic [7:0] Out;
    logic       Branch;
`ifdef ALU_FLAGS_EN
    logic       Zero, Negative, Carry;
`endif

    alu_core #(.WIDTH(8)) dut (
        .Clk(Clk), .ResetN(ResetN), .En(En),
        .AccumulatorIn(AccumulatorIn), .OperandIn(OperandIn), .ImmediateIn(ImmediateIn),
        .Type(Type), .RTypeOP(RTypeOP), .ITypeOP(ITypeOP),
        .Out(Out), .Branch(Branch)
`ifdef ALU_FLAGS_EN
        , .Zero(Zero), .Negative(Negative), .Carry(Carry)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int    out;
        bit    br;
        bit    z;
        bit    n;
        bit    c;
        string name;
    } exp_t;

    exp_t q[$];
    exp_t state;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Reference model: plain integer arithmetic, masked to 8 bits at the end.
    function automatic exp_t model(input exp_t prev, input bit en, input bit typ,
                                   input int rop, input int iop,
                                   input int a, input int b, input int imm);
        exp_t e;
        int   r;
        e = prev;
        if (!en) return e;
        r = a;
        e.br = 0;
        e.c  = 0;
        if (typ) begin
            case (rop)
                0:  r = b;
                1:  r = a & b;
                2:  r = a | b;
                3:  r = a ^ b;
                4:  begin r = a + b; e.c = (a + b) > 255; end
                5:  begin r = a - b; e.c = (a >= b); end
                6:  r = a << (b % 8);
                7:  r = a >> (b % 8);
                8:  r = sgn(a) >>> (b % 8);
                9:  r = ~a;
                10: r = (sgn(a) < sgn(b)) ? 1 : 0;
                11: r = (a < b) ? 1 : 0;
                12: e.br = (a == b);
                13: e.br = (a != b);
                14: e.br = (sgn(a) < sgn(b));
                default: r = a;
            endcase
        end else begin
            case (iop)
                0: r = imm;
                1: begin r = a + imm; e.c = (a + imm) > 255; end
                2: r = a & imm;
                3: r = a | imm;
                4: r = a ^ imm;
                5: r = a << (imm % 8);
                6: r = a >> (imm % 8);
                default: e.br = (a == imm);
            endcase
        end
        e.out = r & 255;
        e.z   = (e.out == 0);
        e.n   = (e.out >= 128);
        return e;
    endfunction

    task automatic step(input string name, input bit en, input bit typ, input int rop,
                        input int iop, input int a, input int b, input int imm);
        @(posedge Clk);
        #2;
        En            = en;
        Type          = typ;
        RTypeOP       = 4'(rop);
        ITypeOP       = 3'(iop);
        AccumulatorIn = 8'(a);
        OperandIn     = 8'(b);
        ImmediateIn   = 8'(imm);
        state      = model(state, en, typ, rop, iop, a & 255, b & 255, imm & 255);
        state.name = name;
        q.push_back(state);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, ".out"}, int'(Out), e.out);
                chk({e.name, ".branch"}, int'(Branch), int'(e.br));
`ifdef ALU_FLAGS_EN
                chk({e.name, ".zero"}, int'(Zero), int'(e.z));
                chk({e.name, ".neg"}, int'(Negative), int'(e.n));
                chk({e.name, ".carry"}, int'(Carry), int'(e.c));
`endif
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge Clk);
            n++;
        end
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain got=%0d want=0 pending items", q.size());
            q.delete();
        end
    endtask

    initial begin : driver
        state = '{out: 0, br: 0, z: 0, n: 0, c: 0, name: "init"};

        // Reset held with random inputs and a running clock.
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #2;
            En = 1'b1; Type = 1'($urandom); RTypeOP = 4'($urandom); ITypeOP = 3'($urandom);
            AccumulatorIn = 8'($urandom); OperandIn = 8'($urandom); ImmediateIn = 8'($urandom);
            @(negedge Clk);
            chk("reset_hold.out", int'(Out), 0);
            chk("reset_hold.branch", int'(Branch), 0);
        end
        En = 1'b0;
        @(negedge Clk);
        ResetN = 1'b1;

        step("idle_after_reset", 0, 1, 4, 0, 8, 16, 0);
        step("add", 1, 1, 4, 0, 8, 16, 0);
        step("sub", 1, 1, 5, 0, 8, 16, 0);
        step("add_wrap", 1, 1, 4, 0, 'hFF, 'h01, 0);
        step("sll", 1, 1, 6, 0, 'h81, 'h03, 0);
        step("srl", 1, 1, 7, 0, 'h81, 'h03, 0);
        step("sra", 1, 1, 8, 0, 'h81, 'h03, 0);
        step("slt", 1, 1, 10, 0, 'h80, 'h01, 0);
        step("sltu", 1, 1, 11, 0, 'h80, 'h01, 0);
        step("beq", 1, 1, 12, 0, 'h55, 'h55, 0);
        step("bne", 1, 1, 13, 0, 'h55, 'h55, 0);
        step("add_after_br", 1, 1, 4, 0, 'h55, 'h55, 0);
        step("li", 1, 0, 0, 0, 'h0F, 0, 'hF0);
        step("addi", 1, 0, 0, 1, 'h0F, 0, 'hF0);
        step("andi", 1, 0, 0, 2, 'h0F, 0, 'hF0);
        step("ori", 1, 0, 0, 3, 'h0F, 0, 'hF0);
        step("beqi", 1, 0, 0, 7, 'h0F, 0, 'h0F);
        step("add24", 1, 1, 4, 0, 8, 16, 0);
        for (int i = 0; i < 3; i++)
            step("en_hold", 0, 1'($urandom), int'($urandom_range(15)), int'($urandom_range(7)),
                 int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)));

        for (int i = 0; i < 400; i++)
            step("random", ($urandom_range(7) != 0), 1'($urandom), int'($urandom_range(15)),
                 int'($urandom_range(7)), int'($urandom_range(255)), int'($urandom_range(255)),
                 int'($urandom_range(255)));
        drain();

        // Asynchronous reset in the middle of a cycle with a non-zero result held.
        step("pre_async", 1, 1, 4, 0, 8, 16, 0);
        drain();
        @(posedge Clk);
        #3;
        ResetN = 1'b0;
        #1;
        chk("async_reset.out", int'(Out), 0);
        chk("async_reset.branch", int'(Branch), 0);
        En = 1'b0;
        @(negedge Clk);
        ResetN = 1'b1;
        state = '{out: 0, br: 0, z: 0, n: 0, c: 0, name: "post_reset"};
        step("post_async_idle", 0, 1, 4, 0, 1, 1, 0);
        step("post_async_beq", 1, 1, 12, 0, 'h33, 'h33, 0);
        step("post_async_sub", 1, 1, 5, 0, 'h10, 'h20, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
